// File: rtl/ddf_flux_rr_sched.sv
// ---------------------------------------------------------------------------
// ddf_flux_rr_sched
//
// Round-robin read scheduler sitting between a shared multi-flux FIFO and a
// single downstream sink. An arbitration cycle picks the next non-empty flux
// starting at the round-robin pointer. The grant then drains up to a
// configurable burst of tokens from that flux at one token per cycle.
// Read data comes back from the FIFO one cycle after the strobe. It is
// registered once more before it is presented downstream, so a read issued
// in cycle t appears as a write in cycle t+2.
//
// Parameters
//   WIDTH    data token width
//   FLUX     number of flux streams (2..8)
//   BURST_W  width of the burst configuration
//
// Ports
//   ck         clock, rising edge
//   rst        asynchronous active-high reset
//   cfg_burst  tokens per grant (0 behaves as 1), sampled only at grant time
//   in_empty   per-flux empty flags from the FIFO
//   in_read    per-flux read strobes to the FIFO (one-hot or zero)
//   in_data    shared FIFO read data, valid the cycle after a strobe
//   full       downstream almost-full (at least 2 entries of slack)
//   wr         downstream write strobe
//   out_data   token to downstream
//   out_flux   source flux of out_data, qualified by wr
//   busy       high while a grant is active
// ---------------------------------------------------------------------------
module ddf_flux_rr_sched #(
    parameter int WIDTH   = 8,
    parameter int FLUX    = 2,
    parameter int BURST_W = 4,
    localparam int FLUX_W = (FLUX > 1) ? $clog2(FLUX) : 1
) (
    input  logic               ck,
    input  logic               rst,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic [FLUX-1:0]    in_empty,
    output logic [FLUX-1:0]    in_read,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               full,
    output logic               wr,
    output logic [WIDTH-1:0]   out_data,
    output logic [FLUX_W-1:0]  out_flux,
    output logic               busy
);

    typedef enum logic {
        ARB  = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [FLUX_W-1:0]  rr_ptr;
    logic [FLUX_W-1:0]  rr_ptr_nxt;
    logic [FLUX_W-1:0]  g;
    logic [FLUX_W-1:0]  g_nxt;
    logic [FLUX_W-1:0]  g_inc;
    logic [BURST_W-1:0] burst;
    logic [BURST_W-1:0] burst_nxt;
    logic [BURST_W:0]   cnt;
    logic [BURST_W:0]   cnt_nxt;
    logic [BURST_W:0]   burst_ext;
    logic               rd_en;
    logic               found;
    logic [FLUX_W-1:0]  found_idx;
    logic               rd_q;
    logic [FLUX_W-1:0]  rd_flux_q;

    // Index of the flux that is 'offs' positions after 'base', wrapping
    // at FLUX. FLUX need not be a power of two, so a plain truncating add
    // would not wrap correctly.
    function automatic logic [FLUX_W-1:0] wrap_idx(
        input logic [FLUX_W-1:0] base,
        input int                offs
    );
        int sum;
        sum = 0;
        sum[FLUX_W-1:0] = base;
        sum = sum + offs;
        if (sum >= FLUX) begin
            sum = sum - FLUX;
        end
        return sum[FLUX_W-1:0];
    endfunction

    // The counter is one bit wider than the burst, so comparisons are done
    // against a zero-extended copy of the latched burst.
    assign burst_ext = {1'b0, burst};

    // Successor of the granted flux. The pointer moves here when a grant
    // is released, which gives the other flux their turn before this one
    // comes round again.
    assign g_inc = (g == FLUX_W'(FLUX - 1)) ? '0 : g + 1'b1;

    assign busy = (state == XFER);

    // Round-robin search: walk the flux starting at rr_ptr and take the
    // first one that has data. Only the arbitration state consumes the
    // result, so the search runs every cycle without side effects.
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        for (int i = 0; i < FLUX; i++) begin
            if (!found && !in_empty[wrap_idx(rr_ptr, i)]) begin
                found     = 1'b1;
                found_idx = wrap_idx(rr_ptr, i);
            end
        end
    end

    // Next-state and read-strobe logic.
    //
    // ARB always costs exactly one cycle and never reads. It latches the
    // grant and the burst length, so later changes to cfg_burst only take
    // effect at the next arbitration.
    //
    // XFER reads whenever the granted flux has data, downstream is not
    // almost-full, and the burst is not used up. The grant is released in
    // the same cycle as the last read of the burst. Releasing then leaves
    // exactly one idle arbitration cycle between grants. The grant is also
    // released when the flux runs dry. An almost-full downstream alone
    // simply holds the grant.
    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        g_nxt      = g;
        burst_nxt  = burst;
        cnt_nxt    = cnt;
        rd_en      = 1'b0;
        in_read    = '0;
        case (state)
            ARB: begin
                if (found) begin
                    g_nxt     = found_idx;
                    burst_nxt = (cfg_burst == '0) ? BURST_W'(1) : cfg_burst;
                    cnt_nxt   = '0;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                rd_en = !in_empty[g] && !full && (cnt < burst_ext);
                if (rd_en) begin
                    in_read[g] = 1'b1;
                    cnt_nxt    = cnt + 1'b1;
                    if ((cnt + 1'b1) == burst_ext) begin
                        state_nxt  = ARB;
                        rr_ptr_nxt = g_inc;
                    end
                end else if (in_empty[g] || (cnt >= burst_ext)) begin
                    state_nxt  = ARB;
                    rr_ptr_nxt = g_inc;
                end
            end
            default: begin
                state_nxt = ARB;
            end
        endcase
    end

    // Control state register. Reset returns to arbitration with flux 0
    // first in line. Because in_read and busy are decoded from this state,
    // both drop as soon as reset is asserted.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state  <= ARB;
            rr_ptr <= '0;
            g      <= '0;
            burst  <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            g      <= g_nxt;
            burst  <= burst_nxt;
            cnt    <= cnt_nxt;
        end
    end

    // Output pipeline.
    //
    // rd_q marks that a read strobe went out last cycle, so in_data is
    // valid now. That data is registered together with the flux it came
    // from, and wr is raised for exactly one cycle per read. Every read
    // therefore yields one write, even if full rises meanwhile; the
    // downstream slack absorbs those writes.
    //
    // Reset clears rd_q, which discards a read that is still in flight.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            rd_q      <= 1'b0;
            rd_flux_q <= '0;
            wr        <= 1'b0;
            out_data  <= '0;
            out_flux  <= '0;
        end else begin
            rd_q      <= rd_en;
            rd_flux_q <= g;
            wr        <= rd_q;
            if (rd_q) begin
                out_data <= in_data;
                out_flux <= rd_flux_q;
            end
        end
    end

endmodule

// File: tb/tb_ddf_flux_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_ddf_flux_rr_sched
//
// Scoreboard bench for ddf_flux_rr_sched with FLUX=2. A small FIFO model
// serves the read strobes: it pops on the edge after a strobe and updates
// in_empty on that edge. Directed scenarios load tokens into the model and
// push the hand-computed write order into the expected queue. A monitor
// pops and compares on every wr. Relative write timing is also checked
// where the cycle behaviour is fixed.
// ---------------------------------------------------------------------------
module tb_ddf_flux_rr_sched;

    localparam int WIDTH   = 8;
    localparam int FLUX    = 2;
    localparam int BURST_W = 4;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [0:0]       flux;
    } exp_t;

    logic               ck        = 1'b0;
    logic               rst       = 1'b1;
    logic [BURST_W-1:0] cfg_burst = '0;
    logic [FLUX-1:0]    in_empty  = '1;
    logic [FLUX-1:0]    in_read;
    logic [WIDTH-1:0]   in_data   = '0;
    logic               full      = 1'b0;
    logic               wr;
    logic [WIDTH-1:0]   out_data;
    logic [0:0]         out_flux;
    logic               busy;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] fq0[$];
    logic [WIDTH-1:0] fq1[$];
    int               stamp_q[$];
    int               exp_gap[$];
    logic [FLUX-1:0]  rd_s = '0;
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    int               wr_count = 0;
    int               wr_base = 0;

    ddf_flux_rr_sched #(
        .WIDTH   (WIDTH),
        .FLUX    (FLUX),
        .BURST_W (BURST_W)
    ) dut (
        .ck        (ck),
        .rst       (rst),
        .cfg_burst (cfg_burst),
        .in_empty  (in_empty),
        .in_read   (in_read),
        .in_data   (in_data),
        .full      (full),
        .wr        (wr),
        .out_data  (out_data),
        .out_flux  (out_flux),
        .busy      (busy)
    );

    // 10 ns clock with a free-running cycle counter for write timestamps.
    always #5 ck = ~ck;

    always @(posedge ck) begin
        cyc <= cyc + 1;
    end

    // FIFO model: strobes sampled at the falling edge are served on the
    // next rising edge. Data and empty flags change by NBA, so the DUT
    // sees them only from the following cycle onwards.
    always @(posedge ck) begin
        if (rd_s[0]) begin
            if (fq0.size() > 0) begin
                in_data <= fq0.pop_front();
            end else begin
                checks++;
                errors++;
                $display("[TB] FAIL fifo_underflow0: got read of empty flux 0, expected no read");
            end
        end
        if (rd_s[1]) begin
            if (fq1.size() > 0) begin
                in_data <= fq1.pop_front();
            end else begin
                checks++;
                errors++;
                $display("[TB] FAIL fifo_underflow1: got read of empty flux 1, expected no read");
            end
        end
        in_empty <= {(fq1.size() == 0), (fq0.size() == 0)};
    end

    // Monitor: samples on the falling edge, checks that in_read is one-hot
    // or zero, and compares every write against the scoreboard.
    always @(negedge ck) begin : monitor
        exp_t e;
        rd_s = in_read;
        checks++;
        if (!$onehot0(in_read)) begin
            errors++;
            $display("[TB] FAIL onehot_in_read: got %b, expected one-hot or zero", in_read);
        end
        if (wr) begin
            wr_count++;
            stamp_q.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_wr: got data %0h flux %0d, expected no write",
                         out_data, out_flux);
            end else begin
                e = exp_q.pop_front();
                if ({out_data, out_flux} !== {e.data, e.flux}) begin
                    errors++;
                    $display("[TB] FAIL wr_token: got data %0h flux %0d, expected data %0h flux %0d",
                             out_data, out_flux, e.data, e.flux);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input int flux, input logic [WIDTH-1:0] data);
        if (flux == 0) begin
            fq0.push_back(data);
        end else begin
            fq1.push_back(data);
        end
    endtask

    task automatic expectTok(input logic [WIDTH-1:0] data, input logic [0:0] flux);
        exp_t e;
        e.data = data;
        e.flux = flux;
        exp_q.push_back(e);
    endtask

    task automatic startScenario(input logic [BURST_W-1:0] b);
        cfg_burst = b;
        stamp_q.delete();
        exp_gap.delete();
        wr_base = wr_count;
    endtask

    task automatic resetDut();
        @(negedge ck);
        rst  = 1'b1;
        full = 1'b0;
        repeat (2) @(negedge ck);
        rst = 1'b0;
    endtask

    // Waits (bounded) for the scoreboard to empty, then idles so that any
    // extra write is caught, and checks FIFO leftovers and write timing.
    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge ck);
            n++;
        end
        checkOutput({name, "_drain"}, exp_q.size(), 0);
        exp_q.delete();
        repeat (10) @(negedge ck);
        checkOutput({name, "_fifo_left"}, fq0.size() + fq1.size(), 0);
        if (exp_gap.size() > 0) begin
            checkOutput({name, "_wr_count"}, stamp_q.size(), exp_gap.size());
            if (stamp_q.size() == exp_gap.size()) begin
                for (int i = 0; i < exp_gap.size(); i++) begin
                    checkOutput($sformatf("%s_gap%0d", name, i), stamp_q[i] - stamp_q[0], exp_gap[i]);
                end
            end
        end
        exp_gap.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        #1;
        checkOutput("rst_in_read", in_read, 0);
        checkOutput("rst_wr", wr, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_flux", out_flux, 0);
        repeat (2) @(negedge ck);
        rst = 1'b0;

        // Burst split: A,B from flux0, D,E from flux1, then C
        @(negedge ck);
        startScenario(4'd2);
        applyStimulus(0, 8'hA1); applyStimulus(0, 8'hB2); applyStimulus(0, 8'hC3);
        applyStimulus(1, 8'hD4); applyStimulus(1, 8'hE5);
        expectTok(8'hA1, 1'b0); expectTok(8'hB2, 1'b0);
        expectTok(8'hD4, 1'b1); expectTok(8'hE5, 1'b1);
        expectTok(8'hC3, 1'b0);
        exp_gap.push_back(0); exp_gap.push_back(1); exp_gap.push_back(3);
        exp_gap.push_back(4); exp_gap.push_back(6);
        waitDrain("split");

        // Early release: flux0 has one token, flux1 has three
        resetDut();
        startScenario(4'd4);
        applyStimulus(0, 8'h11);
        applyStimulus(1, 8'h21); applyStimulus(1, 8'h22); applyStimulus(1, 8'h23);
        expectTok(8'h11, 1'b0);
        expectTok(8'h21, 1'b1); expectTok(8'h22, 1'b1); expectTok(8'h23, 1'b1);
        exp_gap.push_back(0); exp_gap.push_back(3); exp_gap.push_back(4); exp_gap.push_back(5);
        waitDrain("early");

        // Zero burst: one token per grant, alternating flux
        resetDut();
        startScenario(4'd0);
        applyStimulus(0, 8'h31); applyStimulus(0, 8'h32);
        applyStimulus(1, 8'h41); applyStimulus(1, 8'h42);
        expectTok(8'h31, 1'b0); expectTok(8'h41, 1'b1);
        expectTok(8'h32, 1'b0); expectTok(8'h42, 1'b1);
        exp_gap.push_back(0); exp_gap.push_back(2); exp_gap.push_back(4); exp_gap.push_back(6);
        waitDrain("zero");

        // Backpressure after the first read. The cfg_burst change during
        // the grant must not shorten the latched burst of 4.
        resetDut();
        startScenario(4'd4);
        applyStimulus(0, 8'h51); applyStimulus(0, 8'h52);
        applyStimulus(0, 8'h53); applyStimulus(0, 8'h54);
        expectTok(8'h51, 1'b0); expectTok(8'h52, 1'b0);
        expectTok(8'h53, 1'b0); expectTok(8'h54, 1'b0);
        exp_gap.push_back(0); exp_gap.push_back(6); exp_gap.push_back(7); exp_gap.push_back(8);
        @(posedge ck);
        @(posedge ck);
        @(posedge ck);
        #1;
        full = 1'b1;
        cfg_burst = 4'd1;
        repeat (5) begin
            @(negedge ck);
            checkOutput("stall_busy", busy, 1);
            checkOutput("stall_in_read", in_read, 0);
        end
        checkOutput("stall_wr_count", wr_count - wr_base, 1);
        @(posedge ck);
        #1;
        full = 1'b0;
        waitDrain("backpressure");

        // Asynchronous reset mid-grant: the first two tokens are consumed
        // and discarded, and flux0 is granted first afterwards.
        resetDut();
        startScenario(4'd4);
        applyStimulus(0, 8'h61); applyStimulus(0, 8'h62);
        applyStimulus(0, 8'h63); applyStimulus(0, 8'h64);
        applyStimulus(1, 8'h71);
        expectTok(8'h63, 1'b0); expectTok(8'h64, 1'b0); expectTok(8'h71, 1'b1);
        repeat (4) @(posedge ck);
        #1;
        checkOutput("pre_rst_wr", wr, 1);
        checkOutput("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_in_read", in_read, 0);
        checkOutput("async_rst_wr", wr, 0);
        checkOutput("async_rst_busy", busy, 0);
        #1;
        rst = 1'b0;
        waitDrain("async_rst");

        // Idle: nothing to read for 20 cycles
        repeat (20) begin
            @(negedge ck);
            checkOutput("idle_in_read", in_read, 0);
            checkOutput("idle_wr", wr, 0);
            checkOutput("idle_busy", busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddf_flux_rr_sched.md
DDF_FLUX_RR_SCHED -- requirements
Module: ddf_flux_rr_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data token width in bits.
REQ-002 SHALL have parameter FLUX, default 2, range 2..8: number of flux streams sharing the upstream multi-flux FIFO.
REQ-003 SHALL have parameter BURST_W, default 4: width of the burst configuration.
REQ-004 SHALL have port ck, input, 1: the single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port cfg_burst, input, BURST_W: tokens per grant.
REQ-007 SHALL have port in_empty, input, FLUX: per-flux empty flags from the multi-flux FIFO.
REQ-008 SHALL have port in_read, output, FLUX: per-flux read strobes to the FIFO.
REQ-009 SHALL have port in_data, input, WIDTH: shared FIFO dataout, valid the cycle after a read strobe.
REQ-010 SHALL have port full, input, 1: downstream almost-full, with at least 2 entries of slack.
REQ-011 SHALL have port wr, output, 1: downstream write strobe.
REQ-012 SHALL have port out_data, output, WIDTH: token to downstream.
REQ-013 SHALL have port out_flux, output, clog2(FLUX): source flux of out_data, qualified by wr.
REQ-014 SHALL have port busy, output, 1: high while in state XFER.

Function
REQ-015 SHALL implement a two-state FSM, ARB and XFER.
REQ-016 ARB: SHALL search round-robin for the first flux with in_empty low, starting at rr_ptr.
REQ-017 ARB on finding a flux: SHALL latch grant index g, latch burst = (cfg_burst==0 ? 1 : cfg_burst), clear cnt, move to XFER next cycle.
REQ-018 ARB when all flux are empty: SHALL stay in ARB, with no in_read asserted.
REQ-019 ARB SHALL cost exactly one cycle; no read SHALL issue in ARB.
REQ-020 XFER: SHALL assert in_read[g] in a cycle iff in_empty[g]==0 and full==0 and cnt<burst; cnt SHALL increment on each read.
REQ-021 XFER exit: when cnt reaches burst, or in_empty[g]==1 with no read issued that cycle, SHALL return to ARB and set rr_ptr = (g+1) mod FLUX.
REQ-022 full==1 in XFER: SHALL stall the grant; the state is held and the grant is not released.
REQ-023 At most one in_read bit SHALL be high in any cycle; in_read SHALL be combinational from registered state and the current inputs.
REQ-024 Output pipeline: one cycle after in_read[g], out_data<=in_data, out_flux<=g and wr<=1 SHALL be registered, appearing on the outputs the following cycle; otherwise wr<=0 and out_data/out_flux hold.
REQ-025 Latency: in_read cycle t, wr high in cycle t+2. Sustained throughput SHALL be 1 token/cycle within a grant.
REQ-026 Up to 2 tokens MAY be in flight after full rises; each SHALL still be written, never dropped or duplicated.
REQ-027 Token order within a flux SHALL be preserved.
REQ-028 Every issued read SHALL produce exactly one wr.
REQ-029 Changes to cfg_burst during XFER SHALL have no effect until the next ARB.
REQ-030 A flux becoming non-empty during another flux's grant SHALL wait for its round-robin turn.
REQ-031 A single non-empty flux SHALL be re-granted after each ARB cycle.
REQ-032 cnt SHALL be BURST_W+1 bits wide so it cannot wrap.
REQ-033 rr_ptr SHALL wrap from FLUX-1 to 0.

Reset
REQ-034 rst high SHALL immediately force: FSM=ARB, rr_ptr=0, g=0, cnt=0, in_read=0, wr=0, out_data=0, out_flux=0, busy=0.
REQ-035 Reset mid-transfer: in-flight read data SHALL be discarded (no wr); FIFO contents are the FIFO's own concern.
REQ-036 After rst deasserts, flux 0 SHALL have first priority.

Verification
REQ-037 Burst split: FLUX=2, cfg_burst=2, flux0 holds A,B,C and flux1 holds D,E -> wr sequence A,B,D,E,C; out_flux 0,0,1,1,0; one idle ARB cycle between grants.
REQ-038 Early release: cfg_burst=4, flux0 holds 1 token, flux1 holds 3 -> flux0 releases after 1 token, then flux1 delivers 3 tokens.
REQ-039 Zero burst: cfg_burst=0 -> each grant moves exactly 1 token.
REQ-040 Backpressure: full raised after the 1st read of a 4-token burst -> at most 1 extra wr; reads resume when full drops; all 4 tokens delivered in order, none duplicated.
REQ-041 Async reset: rst pulsed between edges while in XFER -> in_read, wr and busy go to 0 at once; the first grant after reset goes to flux0.
REQ-042 Idle: all in_empty=1 for 20 cycles -> in_read=0, wr=0 and busy=0 throughout; every property checks that in_read is one-hot-or-zero.
